// File: rtl/rx_symbol_aligner_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rx_symbol_aligner_pkg
// Brief   : Shared constants, types and helpers for the receive symbol aligner.
// Revision: 1.0 - initial release
// ============================================================================
package rx_symbol_aligner_pkg;

  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;
  localparam int         CNT_W     = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } align_state_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + cnt_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_comma_search.sv
`default_nettype none
// ============================================================================
// Module  : rx_comma_search
// Brief   : Combinational K28.5 search over every bit offset of a 2-word window.
// Revision: 1.0 - initial release
// ============================================================================
module rx_comma_search
  import rx_symbol_aligner_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic [2*DATA_WIDTH-1:0] window,
  output logic [DATA_WIDTH-1:0]   hit,
  output logic                    any_hit,
  output logic [3:0]              hit_off
);

  for (genvar o = 0; o < DATA_WIDTH; o++) begin : g_hit
    assign hit[o] = (window[o +: DATA_WIDTH] == K28_5_RDN) ||
                    (window[o +: DATA_WIDTH] == K28_5_RDP);
  end

  assign any_hit = |hit;

  // Scan from the top so the lowest matching offset is the one that sticks.
  always_comb begin
    hit_off = '0;
    for (int o = DATA_WIDTH - 1; o >= 0; o--) begin
      if (hit[o]) hit_off = 4'(o);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_symbol_aligner.sv
`default_nettype none
// ============================================================================
// Module  : rx_symbol_aligner
// Brief   : K28.5 comma aligner with lock FSM, feeding the elastic buffer.
// Revision: 1.0 - initial release
// ============================================================================
module rx_symbol_aligner
  import rx_symbol_aligner_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 4
) (
  input  logic                  recovered_clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  symbol_lock,
  output logic                  comma_detected,
  output logic [3:0]            align_offset
);

  localparam cnt_t LOCK_MAX = cnt_t'(LOCK_COUNT);
  localparam cnt_t LOSS_MAX = cnt_t'(LOSS_COUNT);

  logic [DATA_WIDTH-1:0]   word_d1;
  logic [DATA_WIDTH-1:0]   word_d2;
  logic [2*DATA_WIDTH-1:0] window;
  logic [DATA_WIDTH-1:0]   hit;
  logic                    any_hit;
  logic [3:0]              hit_off;
  logic [3:0]              next_off;
  logic [DATA_WIDTH-1:0]   aligned;
  logic                    match;
  logic                    realign;

  align_state_t state, state_nxt;
  cnt_t         lock_cnt, lock_cnt_nxt;
  cnt_t         loss_cnt, loss_cnt_nxt;

  assign window = {word_d1, word_d2};

  rx_comma_search #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_comma_search (
    .window  (window),
    .hit     (hit),
    .any_hit (any_hit),
    .hit_off (hit_off)
  );

  assign match    = hit[align_offset];
  assign next_off = realign ? hit_off : align_offset;

  always_comb begin
    aligned = window[DATA_WIDTH-1:0];
    for (int o = 1; o < DATA_WIDTH; o++) begin
      if (next_off == 4'(o)) aligned = window[o +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    loss_cnt_nxt = loss_cnt;
    realign      = 1'b0;
    case (state)
      UNLOCKED: begin
        if (any_hit) begin
          realign      = 1'b1;
          lock_cnt_nxt = cnt_t'(1);
          state_nxt    = (LOCK_COUNT == 1) ? LOCKED : CHECK;
        end
      end
      CHECK: begin
        if (match) begin
          lock_cnt_nxt = sat_inc(lock_cnt);
          if (lock_cnt_nxt >= LOCK_MAX) begin
            state_nxt    = LOCKED;
            loss_cnt_nxt = '0;
          end
        end else if (any_hit) begin
          realign      = 1'b1;
          lock_cnt_nxt = cnt_t'(1);
        end
      end
      LOCKED: begin
        // Offset is frozen while locked; foreign commas only erode confidence.
        if (match) begin
          loss_cnt_nxt = '0;
        end else if (any_hit) begin
          loss_cnt_nxt = sat_inc(loss_cnt);
          if (loss_cnt_nxt >= LOSS_MAX) begin
            state_nxt    = UNLOCKED;
            lock_cnt_nxt = '0;
            loss_cnt_nxt = '0;
          end
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge recovered_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= UNLOCKED;
      lock_cnt    <= '0;
      loss_cnt    <= '0;
      symbol_lock <= 1'b0;
    end else begin
      state       <= state_nxt;
      lock_cnt    <= lock_cnt_nxt;
      loss_cnt    <= loss_cnt_nxt;
      symbol_lock <= (state_nxt == LOCKED);
    end
  end

  always_ff @(posedge recovered_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_d1        <= '0;
      word_d2        <= '0;
      data_out       <= '0;
      comma_detected <= 1'b0;
      align_offset   <= '0;
    end else begin
      word_d1        <= data_in;
      word_d2        <= word_d1;
      data_out       <= aligned;
      comma_detected <= hit[next_off];
      align_offset   <= next_off;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_symbol_aligner.sv
`default_nettype none
// ============================================================================
// Module  : tb_rx_symbol_aligner
// Brief   : Directed vector bench for rx_symbol_aligner.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rx_symbol_aligner;

  localparam logic [9:0] RDN = 10'h17C;
  localparam logic [9:0] RDP = 10'h283;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic [9:0] data_in = '0;
  logic [9:0] data_out;
  logic       symbol_lock;
  logic       comma_detected;
  logic [3:0] align_offset;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0] din;
    logic [9:0] dout;
    logic       lock;
    logic       cd;
    logic [3:0] off;
  } vec_t;

  vec_t vecs[20];

  rx_symbol_aligner #(
    .DATA_WIDTH (10),
    .LOCK_COUNT (4),
    .LOSS_COUNT (4)
  ) dut (
    .recovered_clk  (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .data_out       (data_out),
    .symbol_lock    (symbol_lock),
    .comma_detected (comma_detected),
    .align_offset   (align_offset)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [9:0] e_do, input logic e_lock,
                          input logic e_cd, input logic [3:0] e_off);
    chk({tag, ".data_out"}, 32'(data_out), 32'(e_do));
    chk({tag, ".symbol_lock"}, 32'(symbol_lock), 32'(e_lock));
    chk({tag, ".comma_detected"}, 32'(comma_detected), 32'(e_cd));
    chk({tag, ".align_offset"}, 32'(align_offset), 32'(e_off));
  endtask

  task automatic step(input logic [9:0] w);
    data_in = w;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    data_in = '0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One 4-word slot carrying comma c at bit offset off, then zeros.
  // Outputs are checked after the third edge, when the comma reaches data_out.
  task automatic slot(input string tag, input logic [9:0] c, input int off,
                      input logic [9:0] e_do, input logic e_lock, input logic e_cd,
                      input logic [3:0] e_off);
    logic [19:0] pair;
    pair = {10'b0, c} << off;
    step(pair[9:0]);
    step(pair[19:10]);
    step(10'h000);
    chk_outs(tag, e_do, e_lock, e_cd, e_off);
    step(10'h000);
  endtask

  // data_out while locked at offset 0 and a comma arrives at offset 7.
  function automatic logic [9:0] foreign7(input logic [9:0] c);
    return (c == RDN) ? 10'h200 : 10'h180;
  endfunction

  initial begin
    logic [9:0]  c;
    logic [19:0] pair;

    vecs[0]  = '{10'h17C, 10'h000, 1'b0, 1'b0, 4'd0};
    vecs[1]  = '{10'h000, 10'h000, 1'b0, 1'b0, 4'd0};
    vecs[2]  = '{10'h000, 10'h17C, 1'b0, 1'b1, 4'd0};
    vecs[3]  = '{10'h000, 10'h000, 1'b0, 1'b0, 4'd0};
    vecs[4]  = '{10'h283, 10'h000, 1'b0, 1'b0, 4'd0};
    vecs[5]  = '{10'h000, 10'h000, 1'b0, 1'b0, 4'd0};
    vecs[6]  = '{10'h000, 10'h283, 1'b0, 1'b1, 4'd0};
    vecs[7]  = '{10'h000, 10'h000, 1'b0, 1'b0, 4'd0};
    vecs[8]  = '{10'h17C, 10'h000, 1'b0, 1'b0, 4'd0};
    vecs[9]  = '{10'h000, 10'h000, 1'b0, 1'b0, 4'd0};
    vecs[10] = '{10'h000, 10'h17C, 1'b0, 1'b1, 4'd0};
    vecs[11] = '{10'h000, 10'h000, 1'b0, 1'b0, 4'd0};
    vecs[12] = '{10'h283, 10'h000, 1'b0, 1'b0, 4'd0};
    vecs[13] = '{10'h000, 10'h000, 1'b0, 1'b0, 4'd0};
    vecs[14] = '{10'h000, 10'h283, 1'b1, 1'b1, 4'd0};
    vecs[15] = '{10'h000, 10'h000, 1'b1, 1'b0, 4'd0};
    vecs[16] = '{10'h17C, 10'h000, 1'b1, 1'b0, 4'd0};
    vecs[17] = '{10'h000, 10'h000, 1'b1, 1'b0, 4'd0};
    vecs[18] = '{10'h000, 10'h17C, 1'b1, 1'b1, 4'd0};
    vecs[19] = '{10'h000, 10'h000, 1'b1, 1'b0, 4'd0};

    // Reset then idle
    #1;
    chk_outs("in_reset", 10'h000, 1'b0, 1'b0, 4'd0);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(10'h000);
      chk_outs($sformatf("idle[%0d]", i), 10'h000, 1'b0, 1'b0, 4'd0);
    end

    // Aligned lock, table driven
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].din);
      chk_outs($sformatf("aligned[%0d]", i), vecs[i].dout, vecs[i].lock, vecs[i].cd, vecs[i].off);
    end

    // Misaligned lock at offset 3
    do_reset();
    for (int k = 0; k < 4; k++) begin
      c = k[0] ? RDP : RDN;
      slot($sformatf("mis[%0d]", k), c, 3, c, (k == 3), 1'b1, 4'd3);
      chk($sformatf("mis_data[%0d]", k), 32'(data_out), 32'h0);
    end

    // Realign during CHECK: two at offset 5, then offset 2
    do_reset();
    for (int k = 0; k < 2; k++) begin
      c = k[0] ? RDP : RDN;
      slot($sformatf("re5[%0d]", k), c, 5, c, 1'b0, 1'b1, 4'd5);
    end
    for (int k = 0; k < 4; k++) begin
      c = k[0] ? RDP : RDN;
      slot($sformatf("re2[%0d]", k), c, 2, c, (k == 3), 1'b1, 4'd2);
    end

    // Loss of lock
    do_reset();
    for (int k = 0; k < 4; k++) begin
      c = k[0] ? RDP : RDN;
      slot($sformatf("loss_lock0[%0d]", k), c, 0, c, (k == 3), 1'b1, 4'd0);
    end
    for (int k = 0; k < 3; k++) begin
      c = k[0] ? RDP : RDN;
      slot($sformatf("loss_f3[%0d]", k), c, 7, foreign7(c), 1'b1, 1'b0, 4'd0);
    end
    slot("loss_own", RDP, 0, RDP, 1'b1, 1'b1, 4'd0);
    for (int k = 0; k < 4; k++) begin
      c = k[0] ? RDP : RDN;
      slot($sformatf("loss_f4[%0d]", k), c, 7, foreign7(c), (k != 3), 1'b0, 4'd0);
    end
    for (int k = 0; k < 4; k++) begin
      c = k[0] ? RDP : RDN;
      slot($sformatf("relock7[%0d]", k), c, 7, c, (k == 3), 1'b1, 4'd7);
    end

    // Reset mid-lock, with a comma sitting on data_out
    pair = {10'b0, RDN} << 7;
    step(pair[9:0]);
    step(pair[19:10]);
    step(10'h000);
    chk_outs("pre_rst", RDN, 1'b1, 1'b1, 4'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 10'h000, 1'b0, 1'b0, 4'd0);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      c = k[0] ? RDP : RDN;
      slot($sformatf("post_rst[%0d]", k), c, 0, c, (k == 3), 1'b1, 4'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_symbol_aligner.md
Name: rx_symbol_aligner

Overview:
- Receive-path stage directly upstream of the elastic buffer, in the recovered-clock (elastic buffer write) domain.
- Takes raw, unaligned 10-bit words from the deserializer and searches every bit offset for the K28.5 comma.
- Establishes and holds symbol lock with a small FSM.
- Emits symbol-aligned 10-bit words plus lock status; the output feeds the elastic buffer data_in.

Parameters:
- DATA_WIDTH, 10: symbol width. Only 10 is supported.
- LOCK_COUNT, 4: consecutive commas at the same offset required to declare lock (range 1..15).
- LOSS_COUNT, 4: consecutive commas at a foreign offset while locked that cause loss of lock (range 1..15).

Ports:
- recovered_clk  input  1  recovered receive clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  DATA_WIDTH  raw deserializer word; data_in[0] is the first bit received.
- data_out  output  DATA_WIDTH  aligned symbol, first bit in [0].
- symbol_lock  output  1  high while the FSM is in LOCKED.
- comma_detected  output  1  data_out currently holds an aligned K28.5.
- align_offset  output  4  current bit offset, 0..9.

Behaviour:
- Reset (async assert, sync release): word_d1, word_d2, data_out = 0; align_offset = 0; counters = 0; state = UNLOCKED; symbol_lock = 0; comma_detected = 0.
- Pipeline:
  - Each edge: word_d1 <= data_in; word_d2 <= word_d1.
  - window[19:0] = {word_d1, word_d2}; older word in the low bits.
- Comma search (combinational):
  - hit[o] = (window[o+9:o] == 10'h17C) or (window[o+9:o] == 10'h283), for o = 0..9.
  - 10'h17C is K28.5 RD-, 10'h283 is K28.5 RD+, both first bit in LSB.
  - any_hit = OR of hit. hit_off = lowest o with hit[o] = 1.
- Next offset: next_off = hit_off if any_hit and hit_off != align_offset and the FSM realigns (see below); otherwise align_offset.
- Output registers, each edge:
  - data_out <= window[next_off+9:next_off].
  - comma_detected <= hit[next_off].
  - align_offset <= next_off.
- Latency: a word presented on data_in before edge t appears on data_out after edge t+2 (offset 0), i.e. 3 register stages.
- FSM, evaluated each edge with match = hit[align_offset]:
  - UNLOCKED:
    - any_hit -> realign to hit_off, lock_cnt = 1.
    - If LOCK_COUNT == 1, go LOCKED; else go CHECK.
  - CHECK:
    - match -> lock_cnt++. On reaching LOCK_COUNT, go LOCKED and clear loss_cnt.
    - else any_hit -> realign to hit_off, lock_cnt = 1, stay CHECK.
    - No hit -> hold.
  - LOCKED:
    - Offset is never changed.
    - match -> loss_cnt = 0.
    - else any_hit -> loss_cnt++. On reaching LOSS_COUNT, go UNLOCKED with lock_cnt = loss_cnt = 0; offset is retained.
    - No hit -> hold.
- symbol_lock is registered; it rises on the same edge the state becomes LOCKED and falls on the same edge it leaves LOCKED.
- Boundary rules:
  - Multiple simultaneous hits -> lowest offset wins.
  - A comma straddling the word boundary (o > 0) is detected by construction.
  - Counters saturate and never wrap.
  - data_out is always driven; it is only meaningful while symbol_lock = 1.
  - Reset asserted mid-lock drops symbol_lock immediately (asynchronously).

Decomposition:
- Shared rx package holds:
  - K28_5_RDN = 10'h17C and K28_5_RDP = 10'h283.
  - The state encoding: UNLOCKED = 2'd0, CHECK = 2'd1, LOCKED = 2'd2.
- One natural sub-module, rx_comma_search: purely combinational; window in, hit vector / any_hit / hit_off out.
- The top level holds the pipeline registers, the FSM and the output mux.

Test Plan:
- Reset then idle:
  - Stimulus: data_in = 10'h000 for 20 cycles.
  - Required: data_out = 0, symbol_lock = 0, align_offset = 0, state UNLOCKED throughout.
- Aligned lock:
  - Stimulus: K28.5 (alternating 17C/283) every 4th word at offset 0, data words between.
  - Required: symbol_lock rises 3 cycles after the 4th comma is presented; comma_detected pulses 3 cycles after each comma; align_offset = 0.
- Misaligned lock:
  - Stimulus: the serial stream shifted by 3 bits so commas straddle words.
  - Required: align_offset = 3; data_out reproduces the original unshifted symbols; symbol_lock after 4 commas.
- Realign during CHECK:
  - Stimulus: 2 commas at offset 5, then commas at offset 2.
  - Required: align_offset changes to 2; lock_cnt restarts; lock only after 4 commas at offset 2.
- Loss of lock:
  - Stimulus: locked at offset 0, then 3 commas at offset 7, one at offset 0, then 4 at offset 7.
  - Required: lock held through the first 3 (loss_cnt cleared by the offset-0 comma); symbol_lock falls on the 4th consecutive foreign comma; state UNLOCKED, then relocks at offset 7.
- Reset mid-lock:
  - Stimulus: assert rst_n = 0 asynchronously while locked.
  - Required: symbol_lock, data_out and align_offset go to 0 without waiting for a clock edge; relock proceeds normally after release.
